// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC multi-cycle control path:
// FSM state encoding, opcode classes, ALUOp and PC-source encodings.
package risc16_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_LW       = 4'b0000;
  localparam logic [3:0] OP_SW       = 4'b0001;
  localparam logic [3:0] OP_RTYPE_LO = 4'b0010;
  localparam logic [3:0] OP_RTYPE_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ      = 4'b1011;
  localparam logic [3:0] OP_BNE      = 4'b1100;
  localparam logic [3:0] OP_JMP      = 4'b1101;

  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_ADD   = 2'b10;

  localparam logic [1:0] PCSRC_PLUS2  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // R-type ALU instructions occupy one contiguous opcode range.
  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_RTYPE_LO) && (op <= OP_RTYPE_HI);
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_class_decode.sv
// Combinational opcode-to-class decode. Exactly one class output is high
// for any opcode; anything not recognised lands in illegal_o.
module opcode_class_decode
  import risc16_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       lw_o,
  output logic       sw_o,
  output logic       rtype_o,
  output logic       beq_o,
  output logic       bne_o,
  output logic       jmp_o,
  output logic       illegal_o
);

  // One-hot class decode of the instruction-register opcode field.
  always_comb begin
    lw_o      = (opcode_i == OP_LW);
    sw_o      = (opcode_i == OP_SW);
    rtype_o   = is_rtype(opcode_i);
    beq_o     = (opcode_i == OP_BEQ);
    bne_o     = (opcode_i == OP_BNE);
    jmp_o     = (opcode_i == OP_JMP);
    illegal_o = !((opcode_i == OP_LW) || (opcode_i == OP_SW) || is_rtype(opcode_i) ||
                  (opcode_i == OP_BEQ) || (opcode_i == OP_BNE) || (opcode_i == OP_JMP));
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the 16-bit RISC core.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB and drives ALUOp, register
// file, PC and memory strobes. Memory accesses are handshaked: mem_req stays
// high until and including the cycle mem_ready is seen, and the state moves
// on at the following clock edge. A wait counter bounds every memory access;
// running out of budget sets sticky mem_timeout and parks the FSM in HALT.
//
// Optional build macro MULTICYCLE_ILLEGAL_TRAP_EN: illegal opcodes seen in
// DECODE set sticky illegal_op and go to HALT. Without it illegal opcodes
// behave as NOPs (PC already advanced in FETCH) and illegal_op is tied low.
//
// state_dbg exposes the current FSM state for checkers and debug.
module multicycle_control
  import risc16_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_load,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       busy,
  output logic       mem_timeout,
  output logic       illegal_op,
  output logic [2:0] state_dbg
);

  // The access times out on the wait cycle that would bring the counter to
  // WAIT_MAX; a mem_ready in that same cycle still completes the access.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic       cls_lw, cls_sw, cls_rtype, cls_beq, cls_bne, cls_jmp, cls_illegal;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       illegal_q;
  logic       illegal_set;
`endif

  opcode_class_decode u_decode (
    .opcode_i  (opcode),
    .lw_o      (cls_lw),
    .sw_o      (cls_sw),
    .rtype_o   (cls_rtype),
    .beq_o     (cls_beq),
    .bne_o     (cls_bne),
    .jmp_o     (cls_jmp),
    .illegal_o (cls_illegal)
  );

  // Next-state and output decode; mem_ready and zero gate pulses in-cycle.
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_PLUS2;
    alu_op     = ALUOP_RTYPE;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    busy       = 1'b1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_set = 1'b0;
`endif
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_src   = PCSRC_PLUS2;
          state_d  = ST_DECODE;
        end else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        if (cls_jmp) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
          state_d  = ST_FETCH;
        end else if (cls_illegal) begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          illegal_set = 1'b1;
          state_d     = ST_HALT;
`else
          state_d     = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_lw || cls_sw) begin
          alu_op  = ALUOP_ADD;
          alu_src = 1'b1;
          state_d = ST_MEM;
        end else if (cls_rtype) begin
          alu_op  = ALUOP_RTYPE;
          alu_src = 1'b0;
          state_d = ST_WB;
        end else if (cls_beq || cls_bne) begin
          alu_op   = ALUOP_SUB;
          pc_src   = PCSRC_BRANCH;
          pc_write = cls_beq ? zero : !zero;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        alu_op    = ALUOP_ADD;
        mem_req   = 1'b1;
        mem_read  = cls_lw;
        mem_write = cls_sw;
        if (mem_ready) begin
          state_d = cls_lw ? ST_WB : ST_FETCH;
        end else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = cls_lw;
        state_d    = ST_FETCH;
      end
      ST_HALT: begin
        busy = 1'b0;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Wait counter: counts unanswered request cycles, zero whenever no request
  // is outstanding, so it is already clear on entry to FETCH and MEM.
  always_comb begin
    cnt_d = 8'd0;
    if (mem_req && !mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  assign mem_timeout = timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. The driver applies one input vector per
// cycle and pushes the hand-computed output vector expected for that cycle;
// the monitor pops and compares at the falling edge (or right after an
// asynchronous reset is applied mid-cycle).
//
// Valid/ready: mem_req is the request; the DUT treats a cycle with
// mem_req=1 and mem_ready=1 as the completing cycle of the access.
module tb_multicycle_control;
  import risc16_pkg::*;

  localparam int W = 18;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_read, mem_write, ir_load, pc_write;
  logic [1:0] pc_src, alu_op;
  logic       alu_src, reg_write, mem_to_reg, busy, mem_timeout, illegal_op;
  logic [2:0] state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         sample_tgl = 1'b0;
  int           checks = 0;
  int           failures = 0;

  logic [W-1:0] F_WAIT, F_GO, D_IDLE, D_JMP, E_RTYPE, E_ADDR, E_BR_TAKEN, E_BR_NOT;
  logic [W-1:0] M_LW, M_SW, WB_ALU, WB_MEM, H_TO, H_ILL;

  multicycle_control #(.WAIT_MAX(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_op      (alu_op),
    .alu_src     (alu_src),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .busy        (busy),
    .mem_timeout (mem_timeout),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev(input state_e st, input logic req, rd, wr, irl, pcw,
                                      input logic [1:0] pcs, aop,
                                      input logic asrc, rw, m2r, bsy, to, il);
    return {st, req, rd, wr, irl, pcw, pcs, aop, asrc, rw, m2r, bsy, to, il};
  endfunction

  // Driver: called at posedge+1, applies inputs, queues expectation, waits one cycle.
  task automatic drive(input logic [3:0] op, input logic z, input logic rdy,
                       input logic [W-1:0] exp, input string nm);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Apply reset, check the reset outputs immediately, release after one edge.
  task automatic do_reset(input string nm);
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    #1;
    exp_q.push_back(F_WAIT);
    name_q.push_back(nm);
    sample_tgl = ~sample_tgl;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_rtype(input logic [3:0] op, input string tag);
    drive(op, 1'b0, 1'b1, F_GO,    {tag, "_fetch"});
    drive(op, 1'b0, 1'b1, D_IDLE,  {tag, "_decode"});
    drive(op, 1'b0, 1'b1, E_RTYPE, {tag, "_exec"});
    drive(op, 1'b0, 1'b1, WB_ALU,  {tag, "_wb"});
  endtask

  task automatic run_branch(input logic [3:0] op, input logic z, input logic [W-1:0] e_exp,
                            input string tag);
    drive(op, z, 1'b1, F_GO,   {tag, "_fetch"});
    drive(op, z, 1'b1, D_IDLE, {tag, "_decode"});
    drive(op, z, 1'b1, e_exp,  {tag, "_exec"});
  endtask

  // Monitor / scoreboard
  initial begin
    logic [W-1:0] exp, act;
    string        nm;
    forever begin
      @(negedge clk or sample_tgl);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {state_dbg, mem_req, mem_read, mem_write, ir_load, pc_write, pc_src, alu_op,
               alu_src, reg_write, mem_to_reg, busy, mem_timeout, illegal_op};
        checks++;
        if (act !== exp) begin
          failures++;
          $display("FAIL %s: got %b expected %b (st|req rd wr irl pcw|pcs|aop|asrc rw m2r bsy to il)",
                   nm, act, exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    F_WAIT     = ev(ST_FETCH, 1,1,0,0,0, 2'b00, 2'b00, 0,0,0,1,0,0);
    F_GO       = ev(ST_FETCH, 1,1,0,1,1, 2'b00, 2'b00, 0,0,0,1,0,0);
    D_IDLE     = ev(ST_DECODE,0,0,0,0,0, 2'b00, 2'b00, 0,0,0,1,0,0);
    D_JMP      = ev(ST_DECODE,0,0,0,0,1, 2'b10, 2'b00, 0,0,0,1,0,0);
    E_RTYPE    = ev(ST_EXEC,  0,0,0,0,0, 2'b00, 2'b00, 0,0,0,1,0,0);
    E_ADDR     = ev(ST_EXEC,  0,0,0,0,0, 2'b00, 2'b10, 1,0,0,1,0,0);
    E_BR_TAKEN = ev(ST_EXEC,  0,0,0,0,1, 2'b01, 2'b01, 0,0,0,1,0,0);
    E_BR_NOT   = ev(ST_EXEC,  0,0,0,0,0, 2'b01, 2'b01, 0,0,0,1,0,0);
    M_LW       = ev(ST_MEM,   1,1,0,0,0, 2'b00, 2'b10, 0,0,0,1,0,0);
    M_SW       = ev(ST_MEM,   1,0,1,0,0, 2'b00, 2'b10, 0,0,0,1,0,0);
    WB_ALU     = ev(ST_WB,    0,0,0,0,0, 2'b00, 2'b00, 0,1,0,1,0,0);
    WB_MEM     = ev(ST_WB,    0,0,0,0,0, 2'b00, 2'b00, 0,1,1,1,0,0);
    H_TO       = ev(ST_HALT,  0,0,0,0,0, 2'b00, 2'b00, 0,0,0,0,1,0);
    H_ILL      = ev(ST_HALT,  0,0,0,0,0, 2'b00, 2'b00, 0,0,0,0,0,1);

    opcode = 4'b0100;
    do_reset("reset_state");

    // R-type 0100, zero-wait: 4 cycles then FETCH again
    run_rtype(4'b0100, "rtype_0100");

    // LW with 3 MEM wait cycles: 8 cycles
    drive(OP_LW, 1'b0, 1'b1, F_GO,   "lw_fetch");
    drive(OP_LW, 1'b0, 1'b1, D_IDLE, "lw_decode");
    drive(OP_LW, 1'b0, 1'b1, E_ADDR, "lw_exec");
    for (int i = 0; i < 3; i++) drive(OP_LW, 1'b0, 1'b0, M_LW, "lw_mem_wait");
    drive(OP_LW, 1'b0, 1'b1, M_LW,   "lw_mem_ready");
    drive(OP_LW, 1'b0, 1'b1, WB_MEM, "lw_wb");

    // SW zero-wait: 4 cycles
    drive(OP_SW, 1'b0, 1'b1, F_GO,   "sw_fetch");
    drive(OP_SW, 1'b0, 1'b1, D_IDLE, "sw_decode");
    drive(OP_SW, 1'b0, 1'b1, E_ADDR, "sw_exec");
    drive(OP_SW, 1'b0, 1'b1, M_SW,   "sw_mem");

    // Branches: pc_write gated by zero
    run_branch(OP_BEQ, 1'b1, E_BR_TAKEN, "beq_z1");
    run_branch(OP_BEQ, 1'b0, E_BR_NOT,   "beq_z0");
    run_branch(OP_BNE, 1'b1, E_BR_NOT,   "bne_z1");
    run_branch(OP_BNE, 1'b0, E_BR_TAKEN, "bne_z0");

    // JMP: 2 cycles
    drive(OP_JMP, 1'b0, 1'b1, F_GO,  "jmp_fetch");
    drive(OP_JMP, 1'b0, 1'b1, D_JMP, "jmp_decode");

    // Illegal opcode 1110
    drive(4'b1110, 1'b0, 1'b1, F_GO,   "ill_fetch");
    drive(4'b1110, 1'b0, 1'b1, D_IDLE, "ill_decode");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    drive(4'b1110, 1'b0, 1'b1, H_ILL, "ill_halt");
    drive(4'b1110, 1'b0, 1'b1, H_ILL, "ill_halt_hold");
    do_reset("ill_reset");
`else
    // NOP: straight back to FETCH, flag stays low
    drive(OP_JMP, 1'b0, 1'b1, F_GO,  "ill_nop_fetch");
    drive(OP_JMP, 1'b0, 1'b1, D_JMP, "ill_nop_jmp_decode");
`endif

    // FETCH timeout: 15 unanswered cycles then HALT with mem_timeout
    for (int i = 0; i < 15; i++) drive(OP_LW, 1'b0, 1'b0, F_WAIT, "to_fetch_wait");
    for (int i = 0; i < 3; i++)  drive(OP_LW, 1'b0, 1'b1, H_TO, "to_halt");
    do_reset("to_reset_clears");

    // mem_ready on the 15th cycle wins over the limit
    for (int i = 0; i < 14; i++) drive(OP_JMP, 1'b0, 1'b0, F_WAIT, "lim_fetch_wait");
    drive(OP_JMP, 1'b0, 1'b1, F_GO,  "lim_fetch_ready");
    drive(OP_JMP, 1'b0, 1'b1, D_JMP, "lim_decode_no_timeout");

    // Reset during MEM of SW: write strobe must drop without a clock edge
    drive(OP_SW, 1'b0, 1'b1, F_GO,   "rst_sw_fetch");
    drive(OP_SW, 1'b0, 1'b1, D_IDLE, "rst_sw_decode");
    drive(OP_SW, 1'b0, 1'b1, E_ADDR, "rst_sw_exec");
    opcode    = OP_SW;
    mem_ready = 1'b0;
    exp_q.push_back(M_SW);
    name_q.push_back("rst_sw_mem");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(F_WAIT);
    name_q.push_back("rst_sw_async_abort");
    sample_tgl = ~sample_tgl;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Restart after reset, R-type range boundaries
    run_rtype(4'b0010, "rtype_0010");
    run_rtype(4'b1001, "rtype_1001");
    drive(OP_JMP, 1'b0, 1'b1, F_GO, "final_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
